frame_detect_autocorr: RTL and testbench
========================================

Name: frame_detect_autocorr

Overview:
- Upstream packet detector of the OFDM RX chain; drives FrameFinded into the RX top control.
- Delay-and-correlate over the 802.11a-style short training field (period 16) on the complex baseband stream.
- Asserts FrameFinded as a held level once the normalised autocorrelation has stayed above threshold for a plateau of samples.
- Holds FrameFinded until the downstream packet-done pulse, or until detection is disabled.

Parameters:
- DW, 12, signed width of each I/Q input sample.
- WIN, 16, correlation lag and window length in samples; power of two, fixed at 16 in this release.
- THRESH, 6, threshold numerator in eighths; detect when 8*|C| >= THRESH*P (0.75).
- PLATEAU, 48, consecutive above-threshold valid samples required for detection.
- EMIN, 1024, minimum window energy P for a compare to count.

Ports:
- Clk  in  1  clock.
- Rst_n  in  1  reset, asynchronous, active-low.
- FrameDetectionEnable  in  1  block enable; low forces IDLE and flushes all state.
- DataInEnable  in  1  input sample valid.
- DataInRe  in  DW  signed in-phase sample.
- DataInIm  in  DW  signed quadrature sample.
- PacketDone  in  1  one-cycle pulse from downstream at end of packet; releases FrameFinded.
- FrameFinded  out  1  packet start found; level, held.
- CorrAboveThr  out  1  registered compare flag, for debug.

Behaviour:
- Reset: FrameFinded=0, CorrAboveThr=0, state=IDLE. Delay line, accumulators and counters are cleared.
- States and transitions:
  - IDLE -> WARMUP when FrameDetectionEnable=1.
  - WARMUP -> SEARCH after 2*WIN valid samples (fills delay line and window).
  - SEARCH -> FOUND when plateau count reaches PLATEAU.
  - FOUND -> WARMUP on PacketDone.
  - Any state -> IDLE within 1 cycle of FrameDetectionEnable=0, with full flush.
- The pipeline advances only on DataInEnable=1. Invalid cycles freeze all state, so gaps do not change the result.
- Stage 1: register x[n]; WIN-deep delay line yields x[n-16].
- Stage 2: p = x[n]*conj(x[n-16]), 2*DW+1 bits per component. e = |x[n-16]|^2, 2*DW+1 bits unsigned.
- Stage 3: sliding sums C (complex) and P, each ACCW = 2*DW+1+log2(WIN) = 29 bits.
  - Update rule: add newest product, subtract the product WIN valid samples old (second delay line).
  - No saturation; widths are sized to prevent overflow.
- Stage 4: |C| ≈ max(|Re C|,|Im C|) + min(|Re C|,|Im C|)/2.
  - CorrAboveThr = (8*|C| >= THRESH*P) AND (P >= EMIN).
  - CorrAboveThr is forced to 0 outside SEARCH.
- Plateau counter, SEARCH only:
  - Increments on each valid sample with the flag set.
  - Clears to 0 on a valid sample with the flag clear.
  - Saturates at PLATEAU.
- Latency: FrameFinded rises 4 clock cycles after the DataInEnable cycle of the sample that completes the plateau, assuming valid every cycle.
- FrameFinded stays 1 in FOUND regardless of input. Re-detection is impossible until PacketDone.
- PacketDone in FOUND: FrameFinded=0 next cycle; flush; re-enter WARMUP. PacketDone outside FOUND is ignored.
- Simultaneous events:
  - PacketDone and plateau completion on the same cycle: PacketDone wins, FrameFinded stays 0.
  - Enable low plus any other event: enable wins.
- Reset or enable drop mid-search: counter and sums are discarded. The next detection needs a full warm-up.

Test Plan:
- All-zero input, 500 valid samples -> P < EMIN, FrameFinded stays 0 and CorrAboveThr stays 0.
- Period-16 complex tone (amplitude 1000), valid every cycle -> first compare at sample index 32. Count reaches 48 at index 79. FrameFinded=1 exactly 4 cycles after that input cycle and held.
- 40 periodic samples followed by uncorrelated noise (±1000) -> plateau never reaches 48, FrameFinded stays 0.
- Same stimulus as the tone test, with DataInEnable low every other cycle -> detection at the same sample index 79. FrameFinded=1 4 cycles after the sample-79 valid cycle; latency is not doubled.
- Detected state, then PacketDone pulse -> FrameFinded=0 next cycle. A fresh periodic burst re-detects after 32+48 samples.
- FrameDetectionEnable dropped at sample 60 of a periodic burst and re-raised -> no detection from the old burst. A fresh warm-up is required; Rst_n asserted mid-burst gives the same result.

Source files
------------

// File: rtl/frame_detect_autocorr.sv
// frame_detect_autocorr
//   Packet start detector for the OFDM receiver. Correlates the complex
//   baseband stream against itself delayed by one short-training period
//   (WIN samples). It declares a frame once the normalised correlation
//   |C|/P has stayed at or above THRESH/8 for PLATEAU consecutive valid
//   samples.
//
// Ports
//   Clk                  clock
//   Rst_n                asynchronous active-low reset
//   FrameDetectionEnable block enable; low returns to IDLE and flushes
//                        every register in the block
//   DataInEnable         input sample valid
//   DataInRe / DataInIm  signed I/Q sample, DW bits each
//   PacketDone           end-of-packet pulse from downstream; releases
//                        FrameFinded
//   FrameFinded          level, high while in FOUND
//   CorrAboveThr         registered threshold-compare flag (debug)
//
// Handshake: a sample is consumed on every rising clock edge where
// DataInEnable=1. There is no backpressure. Each pipeline stage carries a
// valid bit, so a bubble in the input adds no latency. The stateful
// elements (delay lines, sums, counters) move only when a valid sample
// passes them.
//
// Pipeline (one register per stage, valid every cycle):
//   S1 x[n] and x[n-WIN] -> S2 products -> S3 sliding sums
//      -> S4 compare + FSM
// FrameFinded therefore rises 4 cycles after the input cycle of the
// sample that completes the plateau.

module frame_detect_autocorr #(
  parameter int DW      = 12,
  parameter int WIN     = 16,
  parameter int THRESH  = 6,
  parameter int PLATEAU = 48,
  parameter int EMIN    = 1024
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          FrameDetectionEnable,
  input  logic          DataInEnable,
  input  logic [DW-1:0] DataInRe,
  input  logic [DW-1:0] DataInIm,
  input  logic          PacketDone,
  output logic          FrameFinded,
  output logic          CorrAboveThr
);

  localparam int PW    = 2*DW + 1;             // product / energy width
  localparam int LOGW  = $clog2(WIN);
  localparam int ACCW  = PW + LOGW;            // sliding-sum width
  localparam int CMPW  = ACCW + 4;             // holds 8*|C| and THRESH*P
  localparam int WARMW = $clog2(2*WIN) + 1;
  localparam int PLATW = $clog2(PLATEAU + 1);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_SEARCH, S_FOUND} state_t;

  state_t             r_state, w_state_next;
  logic [WARMW-1:0]   r_warm_cnt, w_warm_next;
  logic [PLATW-1:0]   r_plat_cnt, w_plat_next, w_plat_inc;
  logic               r_corr, w_corr_next;
  logic               w_flush;

  // ---------------- Stage 1: x[n] and x[n-WIN] ----------------
  logic signed [DW-1:0] r_dl_re [WIN];
  logic signed [DW-1:0] r_dl_im [WIN];
  logic signed [DW-1:0] r_x_re, r_x_im, r_xd_re, r_xd_im;
  logic                 r_v1;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_v1 <= 1'b0;
      r_x_re <= '0; r_x_im <= '0; r_xd_re <= '0; r_xd_im <= '0;
      for (int i = 0; i < WIN; i++) begin
        r_dl_re[i] <= '0;
        r_dl_im[i] <= '0;
      end
    end else if (w_flush) begin
      r_v1 <= 1'b0;
      r_x_re <= '0; r_x_im <= '0; r_xd_re <= '0; r_xd_im <= '0;
      for (int i = 0; i < WIN; i++) begin
        r_dl_re[i] <= '0;
        r_dl_im[i] <= '0;
      end
    end else begin
      r_v1 <= DataInEnable;
      if (DataInEnable) begin
        r_x_re  <= $signed(DataInRe);
        r_x_im  <= $signed(DataInIm);
        // Oldest entry, read before the shift, is the sample WIN valid
        // samples back.
        r_xd_re <= r_dl_re[WIN-1];
        r_xd_im <= r_dl_im[WIN-1];
        r_dl_re[0] <= $signed(DataInRe);
        r_dl_im[0] <= $signed(DataInIm);
        for (int i = 1; i < WIN; i++) begin
          r_dl_re[i] <= r_dl_re[i-1];
          r_dl_im[i] <= r_dl_im[i-1];
        end
      end
    end
  end

  // ---------------- Stage 2: x[n]*conj(x[n-WIN]), |x[n-WIN]|^2 ----------------
  logic signed [PW-1:0] w_a, w_b, w_c, w_d;
  logic signed [PW-1:0] w_ac, w_bd, w_bc, w_ad, w_cc, w_dd;
  logic signed [PW-1:0] r_p_re, r_p_im, r_e;
  logic                 r_v2;

  assign w_a  = {{(PW-DW){r_x_re[DW-1]}},  r_x_re};
  assign w_b  = {{(PW-DW){r_x_im[DW-1]}},  r_x_im};
  assign w_c  = {{(PW-DW){r_xd_re[DW-1]}}, r_xd_re};
  assign w_d  = {{(PW-DW){r_xd_im[DW-1]}}, r_xd_im};
  assign w_ac = w_a * w_c;
  assign w_bd = w_b * w_d;
  assign w_bc = w_b * w_c;
  assign w_ad = w_a * w_d;
  assign w_cc = w_c * w_c;
  assign w_dd = w_d * w_d;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_v2 <= 1'b0; r_p_re <= '0; r_p_im <= '0; r_e <= '0;
    end else if (w_flush) begin
      r_v2 <= 1'b0; r_p_re <= '0; r_p_im <= '0; r_e <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_p_re <= w_ac + w_bd;
        r_p_im <= w_bc - w_ad;
        r_e    <= w_cc + w_dd;
      end
    end
  end

  // ---------------- Stage 3: sliding sums over WIN samples ----------------
  logic signed [PW-1:0]   r_pd_re [WIN];
  logic signed [PW-1:0]   r_pd_im [WIN];
  logic signed [PW-1:0]   r_pd_e  [WIN];
  logic signed [ACCW-1:0] r_c_re, r_c_im, r_pw;
  logic signed [ACCW-1:0] w_new_re, w_new_im, w_new_e, w_old_re, w_old_im, w_old_e;
  logic                   r_v3;

  assign w_new_re = {{LOGW{r_p_re[PW-1]}}, r_p_re};
  assign w_new_im = {{LOGW{r_p_im[PW-1]}}, r_p_im};
  assign w_new_e  = {{LOGW{1'b0}}, r_e};
  assign w_old_re = {{LOGW{r_pd_re[WIN-1][PW-1]}}, r_pd_re[WIN-1]};
  assign w_old_im = {{LOGW{r_pd_im[WIN-1][PW-1]}}, r_pd_im[WIN-1]};
  assign w_old_e  = {{LOGW{1'b0}}, r_pd_e[WIN-1]};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_v3 <= 1'b0; r_c_re <= '0; r_c_im <= '0; r_pw <= '0;
      for (int i = 0; i < WIN; i++) begin
        r_pd_re[i] <= '0; r_pd_im[i] <= '0; r_pd_e[i] <= '0;
      end
    end else if (w_flush) begin
      r_v3 <= 1'b0; r_c_re <= '0; r_c_im <= '0; r_pw <= '0;
      for (int i = 0; i < WIN; i++) begin
        r_pd_re[i] <= '0; r_pd_im[i] <= '0; r_pd_e[i] <= '0;
      end
    end else begin
      r_v3 <= r_v2;
      if (r_v2) begin
        // Add the newest term and drop the one that leaves the window.
        r_c_re <= r_c_re + w_new_re - w_old_re;
        r_c_im <= r_c_im + w_new_im - w_old_im;
        r_pw   <= r_pw   + w_new_e  - w_old_e;
        r_pd_re[0] <= r_p_re;
        r_pd_im[0] <= r_p_im;
        r_pd_e[0]  <= r_e;
        for (int i = 1; i < WIN; i++) begin
          r_pd_re[i] <= r_pd_re[i-1];
          r_pd_im[i] <= r_pd_im[i-1];
          r_pd_e[i]  <= r_pd_e[i-1];
        end
      end
    end
  end

  // ---------------- Stage 4: magnitude estimate and threshold ----------------
  logic [ACCW-1:0] w_abs_re, w_abs_im, w_max, w_min;
  logic [ACCW:0]   w_mag;
  logic [CMPW-1:0] w_lhs, w_rhs;
  logic            w_above;

  // Two's-complement negate; the most negative value maps to 2^(ACCW-1),
  // which is still correct when read as unsigned.
  assign w_abs_re = r_c_re[ACCW-1] ? (~r_c_re + ACCW'(1)) : r_c_re;
  assign w_abs_im = r_c_im[ACCW-1] ? (~r_c_im + ACCW'(1)) : r_c_im;
  assign w_max    = (w_abs_re >= w_abs_im) ? w_abs_re : w_abs_im;
  assign w_min    = (w_abs_re >= w_abs_im) ? w_abs_im : w_abs_re;
  assign w_mag    = {1'b0, w_max} + {2'b00, w_min[ACCW-1:1]};
  assign w_lhs    = {w_mag, 3'b000};
  assign w_rhs    = CMPW'(THRESH) * {4'b0000, r_pw};
  assign w_above  = (w_lhs >= w_rhs) && (r_pw >= ACCW'(EMIN));

  assign w_plat_inc = (r_plat_cnt == PLATW'(PLATEAU)) ? r_plat_cnt
                                                      : r_plat_cnt + PLATW'(1);

  // ---------------- Control FSM ----------------
  always_comb begin
    w_state_next = r_state;
    w_warm_next  = r_warm_cnt;
    w_plat_next  = r_plat_cnt;
    w_corr_next  = 1'b0;
    w_flush      = 1'b0;
    if (!FrameDetectionEnable) begin
      w_state_next = S_IDLE;
      w_warm_next  = '0;
      w_plat_next  = '0;
      w_flush      = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = S_WARMUP;
          w_warm_next  = '0;
          w_plat_next  = '0;
        end
        S_WARMUP: begin
          // Wait until the sample delay line and the window are both full.
          if (r_v3) begin
            if (r_warm_cnt == WARMW'(2*WIN-1)) begin
              w_state_next = S_SEARCH;
              w_warm_next  = '0;
            end else begin
              w_warm_next = r_warm_cnt + WARMW'(1);
            end
          end
        end
        S_SEARCH: begin
          w_corr_next = r_corr;
          if (r_v3) begin
            w_corr_next = w_above;
            w_plat_next = w_above ? w_plat_inc : '0;
          end
          if (w_plat_next == PLATW'(PLATEAU)) begin
            w_corr_next = 1'b0;
            w_plat_next = '0;
            // A packet-done pulse coinciding with plateau completion
            // cancels the detection and restarts the warm-up.
            if (PacketDone) begin
              w_state_next = S_WARMUP;
              w_flush      = 1'b1;
            end else begin
              w_state_next = S_FOUND;
            end
          end
        end
        S_FOUND: begin
          if (PacketDone) begin
            w_state_next = S_WARMUP;
            w_flush      = 1'b1;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_IDLE;
      r_warm_cnt <= '0;
      r_plat_cnt <= '0;
      r_corr     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_warm_cnt <= w_warm_next;
      r_plat_cnt <= w_plat_next;
      r_corr     <= w_corr_next;
    end
  end

  assign FrameFinded  = (r_state == S_FOUND);
  assign CorrAboveThr = r_corr;

endmodule

// File: tb/tb_frame_detect_autocorr.sv
module tb_frame_detect_autocorr;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        FrameDetectionEnable = 1'b0;
  logic        DataInEnable = 1'b0;
  logic [11:0] DataInRe = '0;
  logic [11:0] DataInIm = '0;
  logic        PacketDone = 1'b0;
  logic        FrameFinded;
  logic        CorrAboveThr;

  frame_detect_autocorr dut (
    .Clk                  (Clk),
    .Rst_n                (Rst_n),
    .FrameDetectionEnable (FrameDetectionEnable),
    .DataInEnable         (DataInEnable),
    .DataInRe             (DataInRe),
    .DataInIm             (DataInIm),
    .PacketDone           (PacketDone),
    .FrameFinded          (FrameFinded),
    .CorrAboveThr         (CorrAboveThr)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic        en;
    logic        pd;
    logic [11:0] re;
    logic [11:0] im;
    logic        exp_ff;
    logic        exp_corr;
  } vec_t;

  vec_t vecs[256];
  int   n_vecs;

  logic [11:0] tone_re[16];
  logic [11:0] tone_im[16];

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0b expected=%0b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, #1 after the rising edge.
  task automatic drive(input logic fde, input logic en, input logic [11:0] re,
                       input logic [11:0] im, input logic pd);
    @(posedge Clk);
    #1;
    FrameDetectionEnable = fde;
    DataInEnable         = en;
    DataInRe             = re;
    DataInIm             = im;
    PacketDone           = pd;
  endtask

  function automatic logic [11:0] noise();
    return ($urandom_range(0, 1) == 1) ? 12'd1000 : 12'hC18; // +1000 / -1000
  endfunction

  task automatic drop_enable();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // Row 0 is an idle cycle with enable raised; tone sample n follows.
  // Expected outputs: flag visible 4 rows after the input row of sample 32,
  // detection visible 4 rows after sample 79.
  task automatic build_tone(input bit gap, input bit collide);
    int c32, c79, n;
    c32 = gap ? 1 + 2*32 : 1 + 32;
    c79 = gap ? 1 + 2*79 : 1 + 79;
    n_vecs = c79 + 24;
    for (int c = 0; c < n_vecs; c++) begin
      if (c == 0) begin
        vecs[c].en = 1'b0; n = 0;
      end else if (gap) begin
        vecs[c].en = ((c - 1) % 2 == 0); n = (c - 1) / 2;
      end else begin
        vecs[c].en = 1'b1; n = c - 1;
      end
      vecs[c].re       = vecs[c].en ? tone_re[n % 16] : 12'd777;
      vecs[c].im       = vecs[c].en ? tone_im[n % 16] : 12'hDD5;
      vecs[c].pd       = collide && (c == c79 + 3);
      vecs[c].exp_ff   = !collide && (c >= c79 + 4);
      vecs[c].exp_corr = (c >= c32 + 4) && (c < c79 + 4);
    end
  endtask

  task automatic apply_vecs(input string tag);
    logic [1:0] e;
    for (int i = 0; i < n_vecs; i++) begin
      drive(1'b1, vecs[i].en, vecs[i].re, vecs[i].im, vecs[i].pd);
      exp_q.push_back({vecs[i].exp_ff, vecs[i].exp_corr});
      @(negedge Clk);
      e = exp_q.pop_front();
      check($sformatf("%s[%0d].ff", tag, i), FrameFinded, e[1]);
      check($sformatf("%s[%0d].corr", tag, i), CorrAboveThr, e[0]);
    end
    DataInEnable = 1'b0;
    PacketDone   = 1'b0;
  endtask

  // Enable, then send tone samples 0..cnt-1 with no detection expected.
  task automatic partial_burst(input string tag, input int cnt);
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    for (int n = 0; n < cnt; n++) begin
      drive(1'b1, 1'b1, tone_re[n % 16], tone_im[n % 16], 1'b0);
      @(negedge Clk);
      check($sformatf("%s.ff[%0d]", tag, n), FrameFinded, 1'b0);
    end
    check({tag, ".corr_before_abort"}, CorrAboveThr, 1'b1);
  endtask

  initial begin
    tone_re = '{12'd1000, 12'd924, 12'd707, 12'd383, 12'd0, 12'hE81, 12'hD3D, 12'hC64,
                12'hC18, 12'hC64, 12'hD3D, 12'hE81, 12'd0, 12'd383, 12'd707, 12'd924};
    for (int k = 0; k < 16; k++) tone_im[k] = tone_re[(k + 12) % 16];

    // ---------- reset ----------
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset.ff", FrameFinded, 1'b0);
    check("reset.corr", CorrAboveThr, 1'b0);
    #1 Rst_n = 1'b1;

    // ---------- all-zero input: energy below EMIN ----------
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    for (int n = 0; n < 500; n++) begin
      drive(1'b1, 1'b1, '0, '0, 1'b0);
      @(negedge Clk);
      check($sformatf("zero.ff[%0d]", n), FrameFinded, 1'b0);
      check($sformatf("zero.corr[%0d]", n), CorrAboveThr, 1'b0);
    end
    drop_enable();

    // ---------- tone, valid every cycle ----------
    build_tone(1'b0, 1'b0);
    apply_vecs("tone");

    // FOUND holds regardless of input
    for (int n = 0; n < 20; n++) begin
      drive(1'b1, 1'b1, noise(), noise(), 1'b0);
      @(negedge Clk);
      check($sformatf("hold.ff[%0d]", n), FrameFinded, 1'b1);
      check($sformatf("hold.corr[%0d]", n), CorrAboveThr, 1'b0);
    end

    // PacketDone releases the detection on the next cycle
    drive(1'b1, 1'b0, '0, '0, 1'b1);
    @(negedge Clk);
    check("pd.ff_same_cycle", FrameFinded, 1'b1);
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    @(negedge Clk);
    check("pd.ff_next_cycle", FrameFinded, 1'b0);

    // fresh burst re-detects after 32+48 samples
    build_tone(1'b0, 1'b0);
    apply_vecs("redetect");
    drop_enable();

    // ---------- 40 periodic samples, then noise ----------
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    for (int n = 0; n < 200; n++) begin
      if (n < 40) drive(1'b1, 1'b1, tone_re[n % 16], tone_im[n % 16], 1'b0);
      else        drive(1'b1, 1'b1, noise(), noise(), 1'b0);
      @(negedge Clk);
      check($sformatf("noise.ff[%0d]", n), FrameFinded, 1'b0);
    end
    drop_enable();

    // ---------- tone with a bubble every other cycle ----------
    build_tone(1'b1, 1'b0);
    apply_vecs("gap");
    drop_enable();

    // ---------- enable dropped at sample 60 ----------
    partial_burst("ena_abort", 60);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge Clk);
    check("ena_abort.ff_off", FrameFinded, 1'b0);
    check("ena_abort.corr_off", CorrAboveThr, 1'b0);
    build_tone(1'b0, 1'b0);
    apply_vecs("ena_rewarm");
    drop_enable();

    // ---------- reset asserted at sample 60 ----------
    partial_burst("rst_abort", 60);
    @(posedge Clk);
    #1 Rst_n = 1'b0;
    DataInEnable = 1'b0;
    @(negedge Clk);
    check("rst_abort.ff_off", FrameFinded, 1'b0);
    check("rst_abort.corr_off", CorrAboveThr, 1'b0);
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    build_tone(1'b0, 1'b0);
    apply_vecs("rst_rewarm");
    drop_enable();

    // ---------- PacketDone coincides with plateau completion ----------
    build_tone(1'b0, 1'b1);
    apply_vecs("collide");
    drop_enable();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
